addmult_rr_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined add-multiply unit, computing (a+b)*(c+d), among 4 requesters.
- Each requester presents a four-operand job with a valid/ready handshake.
- The block grants one requester per cycle and runs the job through a 2-stage pipeline: add, then multiply.
- It returns the product tagged with the requester index on a single result port with backpressure.
- It sits between several DSP clients and the single shared multiplier resource.

---
 rtl/addmult_rr_sched.sv | 102 ++++++++++
 tb/tb_addmult_rr_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/addmult_rr_sched.sv
// Round-robin scheduler sharing one 2-stage (a+b)*(c+d) pipeline among 4 requesters.
// Results leave on a single valid/ready port tagged with the owning requester index.
module addmult_rr_sched #(
  parameter int IW   = 10,
  parameter int OW   = 2 * IW,
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*IW-1:0]  req_a,
  input  logic [NREQ*IW-1:0]  req_b,
  input  logic [NREQ*IW-1:0]  req_c,
  input  logic [NREQ*IW-1:0]  req_d,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [OW-1:0]       res_data,
  output logic [1:0]          res_id,
  output logic [1:0]          inflight
);

  logic [1:0]    ptr;
  logic [1:0]    win;
  logic          found;
  logic          adv;
  logic          accept;
  logic [IW-1:0] a_sel, b_sel, c_sel, d_sel;
  logic [OW-1:0] prod;

  logic          s1_valid;
  logic [IW-1:0] s1_sum0;
  logic [IW-1:0] s1_sum1;
  logic [1:0]    s1_id;
  logic          s2_valid;
  logic [OW-1:0] s2_prod;
  logic [1:0]    s2_id;

  assign adv = !(s2_valid && !res_ready);

  // Search starts one past the last grant and wraps; the last grant itself is checked last.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found && adv) req_ready[win] = 1'b1;
  end

  assign accept = found && adv;

  assign a_sel = req_a[win*IW +: IW];
  assign b_sel = req_b[win*IW +: IW];
  assign c_sel = req_c[win*IW +: IW];
  assign d_sel = req_d[win*IW +: IW];

  assign prod = {{(OW-IW){1'b0}}, s1_sum0} * {{(OW-IW){1'b0}}, s1_sum1};

  // Data registers load only behind a valid job; bubbles advance just the valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 2'd3;
      s1_valid <= 1'b0;
      s1_sum0  <= '0;
      s1_sum1  <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_id    <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) begin
        ptr     <= win;
        s1_sum0 <= a_sel + b_sel;
        s1_sum1 <= c_sel + d_sel;
        s1_id   <= win;
      end
      if (s1_valid) begin
        s2_prod <= prod;
        s2_id   <= s1_id;
      end
    end
  end

  assign res_valid = s2_valid;
  assign res_data  = s2_prod;
  assign res_id    = s2_id;
  assign inflight  = {1'b0, s1_valid} + {1'b0, s2_valid};

endmodule

// File: tb/tb_addmult_rr_sched.sv
// Directed-vector bench for addmult_rr_sched: a per-cycle table of stimulus and
// hand-computed outputs, plus a hand-written asynchronous reset sequence.
module tb_addmult_rr_sched;

  localparam int IW = 10;
  localparam int OW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [39:0]   req_a, req_b, req_c, req_d;
  logic          res_valid;
  logic          res_ready;
  logic [19:0]   res_data;
  logic [1:0]    res_id;
  logic [1:0]    inflight;

  int errors = 0;
  int checks = 0;

  addmult_rr_sched #(.IW(IW), .OW(OW), .NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_d     (req_d),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [39:0] a, b, c, d;
    logic        rr;
    logic [3:0]  e_rdy;
    logic        e_val;
    logic [19:0] e_data;
    logic [1:0]  e_id;
    logic [1:0]  e_infl;
  } vec_t;

  vec_t vt[$];

  logic [39:0] ra, rb, rc, rd;   // round-robin lane operands
  logic [39:0] wa1, wb1, wc1, wd1, wa2, wb2, wc2, wd2;

  function automatic logic [39:0] pack(input int x0, input int x1, input int x2, input int x3);
    pack = {10'(x3), 10'(x2), 10'(x1), 10'(x0)};
  endfunction

  task automatic add(input logic r, input logic [3:0] rv,
                     input logic [39:0] a, input logic [39:0] b,
                     input logic [39:0] c, input logic [39:0] d,
                     input logic rr, input logic [3:0] e_rdy, input logic e_val,
                     input int e_data, input int e_id, input int e_infl);
    vec_t v;
    v.rst = r; v.rv = rv; v.a = a; v.b = b; v.c = c; v.d = d; v.rr = rr;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_data = 20'(e_data);
    v.e_id = 2'(e_id); v.e_infl = 2'(e_infl);
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, exp);
    end
  endtask

  // Round-robin lanes: 7*11=77, 30*70=2100, 300*3=900, 1000*1023=1023000
  initial begin
    ra = pack(3, 10, 100, 500);
    rb = pack(4, 20, 200, 500);
    rc = pack(5, 30, 1, 1000);
    rd = pack(6, 40, 2, 23);
    // (1023+1)%1024=0 -> 0 ; 1023*1023=1046529
    wa1 = pack(1023, 0, 0, 0); wb1 = pack(1, 0, 0, 0);
    wc1 = pack(1023, 0, 0, 0); wd1 = pack(1023, 0, 0, 0);
    wa2 = pack(1023, 0, 0, 0); wb2 = pack(0, 0, 0, 0);
    wc2 = pack(1023, 0, 0, 0); wd2 = pack(0, 0, 0, 0);

    //   rst rv       a    b    c    d    rr  rdy     val data     id infl
    add(1, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 0, 0,       0, 0);
    // single job
    add(0, 4'b0001, ra,  rb,  rc,  rd,  1, 4'b0001, 0, 0,       0, 0);
    add(0, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 0, 0,       0, 1);
    add(0, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 1, 77,      0, 1);
    add(0, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 0, 0,       0, 0);
    // fresh reset, then all requesters valid
    add(1, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 0, 0,       0, 0);
    add(0, 4'b1111, ra,  rb,  rc,  rd,  1, 4'b0001, 0, 0,       0, 0);
    add(0, 4'b1111, ra,  rb,  rc,  rd,  1, 4'b0010, 0, 0,       0, 1);
    add(0, 4'b1111, ra,  rb,  rc,  rd,  1, 4'b0100, 1, 77,      0, 2);
    add(0, 4'b1111, ra,  rb,  rc,  rd,  1, 4'b1000, 1, 2100,    1, 2);
    add(0, 4'b1111, ra,  rb,  rc,  rd,  1, 4'b0001, 1, 900,     2, 2);
    add(0, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 1, 1023000, 3, 2);
    add(0, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 1, 77,      0, 1);
    add(0, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 0, 0,       0, 0);
    // wrap arithmetic (ptr=0, only requester 0 valid)
    add(0, 4'b0001, wa1, wb1, wc1, wd1, 1, 4'b0001, 0, 0,       0, 0);
    add(0, 4'b0001, wa2, wb2, wc2, wd2, 1, 4'b0001, 0, 0,       0, 1);
    add(0, 4'b0000, wa2, wb2, wc2, wd2, 1, 4'b0000, 1, 0,       0, 2);
    add(0, 4'b0000, wa2, wb2, wc2, wd2, 1, 4'b0000, 1, 1046529, 0, 1);
    add(0, 4'b0000, wa2, wb2, wc2, wd2, 1, 4'b0000, 0, 0,       0, 0);
    // priority rotation: grant 2, then 0101 -> 0, then 0101 -> 2
    add(0, 4'b0100, ra,  rb,  rc,  rd,  1, 4'b0100, 0, 0,       0, 0);
    add(0, 4'b0101, ra,  rb,  rc,  rd,  1, 4'b0001, 0, 0,       0, 1);
    add(0, 4'b0101, ra,  rb,  rc,  rd,  1, 4'b0100, 1, 900,     2, 2);
    add(0, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 1, 77,      0, 2);
    add(0, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 1, 900,     2, 1);
    add(0, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 0, 0,       0, 0);
    // backpressure: ptr=2, grants 3 then 0, stall 5 cycles, requester 1 waits
    add(0, 4'b1111, ra,  rb,  rc,  rd,  1, 4'b1000, 0, 0,       0, 0);
    add(0, 4'b1111, ra,  rb,  rc,  rd,  1, 4'b0001, 0, 0,       0, 1);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0010, ra, rb, rc, rd,   0, 4'b0000, 1, 1023000, 3, 2);
    add(0, 4'b0010, ra,  rb,  rc,  rd,  1, 4'b0010, 1, 1023000, 3, 2);
    add(0, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 1, 77,      0, 2);
    add(0, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 1, 2100,    1, 1);
    add(0, 4'b0000, ra,  rb,  rc,  rd,  1, 4'b0000, 0, 0,       0, 0);
  end

  initial begin
    rst = 1'b1; req_valid = '0; res_ready = 1'b1;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    #1;

    foreach (vt[i]) begin
      @(negedge clk);
      rst = vt[i].rst; req_valid = vt[i].rv; res_ready = vt[i].rr;
      req_a = vt[i].a; req_b = vt[i].b; req_c = vt[i].c; req_d = vt[i].d;
      #1;
      chk("req_ready", i, 32'(req_ready), 32'(vt[i].e_rdy));
      chk("res_valid", i, 32'(res_valid), 32'(vt[i].e_val));
      chk("inflight",  i, 32'(inflight),  32'(vt[i].e_infl));
      if (vt[i].e_val || vt[i].rst) begin
        chk("res_data", i, 32'(res_data), 32'(vt[i].e_data));
        chk("res_id",   i, 32'(res_id),   32'(vt[i].e_id));
      end
    end

    // Asynchronous reset with two jobs in flight; last grant before reset is requester 0.
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b0001; res_ready = 1'b1;
    req_a = ra; req_b = rb; req_c = rc; req_d = rd;
    @(negedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("pre_rst_inflight", 100, 32'(inflight), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_res_valid", 101, 32'(res_valid), 32'd0);
    chk("rst_inflight",  102, 32'(inflight),  32'd0);
    chk("rst_req_ready", 103, 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_rst_no_stale", 104 + k, 32'(res_valid), 32'd0);
      @(negedge clk);
    end
    // A stale ptr of 0 would pick requester 3; reset ptr=3 picks requester 0.
    req_valid = 4'b1001;
    #1;
    chk("post_rst_priority", 107, 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    chk("post_rst_res_valid", 108, 32'(res_valid), 32'd1);
    chk("post_rst_res_data",  109, 32'(res_data),  32'd77);
    chk("post_rst_res_id",    110, 32'(res_id),    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
